// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pic_pkg
// Purpose  : Shared types and constants for the 8259-style acknowledge path.
//            Holds the acknowledge FSM state encoding, OCW2 {R,SL,EOI}
//            command codes, level/width constants and a one-hot-to-level
//            helper.
// Config   : Macro PIC_AEOI_EN gives meaning to ROT_AEOI_SET/ROT_AEOI_CLR.
// Revision : 1.0 - initial release
// ============================================================================
package pic_pkg;

  localparam int PIC_LEVEL_W = 3;
  localparam int PIC_NUM_IR  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    GAP  = 2'd2,
    ACK2 = 2'd3
  } pic_state_e;

  // OCW2 command field {R, SL, EOI}
  localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] NSEOI        = 3'b001;
  localparam logic [2:0] OCW2_NOP     = 3'b010;
  localparam logic [2:0] SEOI         = 3'b011;
  localparam logic [2:0] ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] ROT_NSEOI    = 3'b101;
  localparam logic [2:0] SET_PRI      = 3'b110;
  localparam logic [2:0] ROT_SEOI     = 3'b111;

  // Encode a one-hot request into its level number (0 for an all-zero input).
  function automatic logic [PIC_LEVEL_W-1:0] onehot_to_level(
    input logic [PIC_NUM_IR-1:0] oh
  );
    logic [PIC_LEVEL_W-1:0] lvl;
    lvl = '0;
    for (int i = 0; i < PIC_NUM_IR; i++) begin
      if (oh[i]) begin
        lvl = lvl | PIC_LEVEL_W'(i);
      end
    end
    return lvl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pic_isr_highest.sv
`default_nettype none
// ============================================================================
// Module   : pic_isr_highest
// Purpose  : Combinational search for the highest-priority set bit of the
//            in-service register. Priority starts at level rotate_i and
//            descends through rotate_i+1, rotate_i+2, ... wrapping mod 8.
// Ports    : isr_i      in  8  in-service register
//            rotate_i   in  3  level currently holding highest priority
//            onehot_o   out 8  one-hot mask of the winning bit (0 if none)
//            level_o    out 3  level number of the winning bit
//            valid_o    out 1  at least one isr bit is set
// Revision : 1.0 - initial release
// ============================================================================
module pic_isr_highest
  import pic_pkg::*;
(
  input  logic [PIC_NUM_IR-1:0]  isr_i,
  input  logic [PIC_LEVEL_W-1:0] rotate_i,
  output logic [PIC_NUM_IR-1:0]  onehot_o,
  output logic [PIC_LEVEL_W-1:0] level_o,
  output logic                   valid_o
);

  logic                   found;
  logic [PIC_LEVEL_W-1:0] idx;

  always_comb begin
    onehot_o = '0;
    level_o  = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < PIC_NUM_IR; i++) begin
      // 3-bit add wraps naturally from level 7 back to level 0
      idx = rotate_i + PIC_LEVEL_W'(i);
      if (!found && isr_i[idx]) begin
        found         = 1'b1;
        level_o       = idx;
        onehot_o[idx] = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/pic_ack_controller.sv
`default_nettype none
// ============================================================================
// Module   : pic_ack_controller
// Purpose  : CPU-facing side of the 8259 interrupt path. Raises INT from the
//            resolver's one-hot winner, runs the two-pulse 8086 INTA
//            handshake, sets ISR on the first pulse, drives the vector byte on
//            the second pulse and clears ISR on OCW2 EOI commands. Owns isr
//            and priority_rotate, which feed back to the priority resolver.
// Config   : PIC_AEOI_EN - adds input aeoi and the rotate-in-AEOI flag
//            (OCW2 100 sets, 000 clears); with aeoi=1 the end of the second
//            INTA pulse clears the served ISR bit automatically.
// Ports    : clk, reset              clock, synchronous active-high reset
//            interrupt_vector in 8   one-hot winner, 0 = no request
//            inta_n           in 1   acknowledge, active-low, synchronised
//            aeoi             in 1   auto-EOI enable (PIC_AEOI_EN only)
//            vector_base      in 5   T7..T3
//            ocw2_wr/ocw2     in 1/8 OCW2 write strobe and data
//            irr_clear        out 8  one-cycle clear pulse to IRR
//            isr              out 8  in-service register
//            priority_rotate  out 3  highest-priority level
//            int_out          out 1  interrupt request to CPU
//            data_out/data_oe out 8/1 vector byte and its drive enable
// Revision : 1.0 - initial release
// ============================================================================
module pic_ack_controller
  import pic_pkg::*;
#(
  parameter int                     NUM_IR         = 8,
  parameter logic [PIC_LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_IR-1:0]      interrupt_vector,
  input  logic                   inta_n,
`ifdef PIC_AEOI_EN
  input  logic                   aeoi,
`endif
  input  logic [4:0]             vector_base,
  input  logic                   ocw2_wr,
  input  logic [7:0]             ocw2,
  output logic [NUM_IR-1:0]      irr_clear,
  output logic [NUM_IR-1:0]      isr,
  output logic [PIC_LEVEL_W-1:0] priority_rotate,
  output logic                   int_out,
  output logic [7:0]             data_out,
  output logic                   data_oe
);

  pic_state_e             state_q, state_d;
  logic                   inta_q;
  logic [NUM_IR-1:0]      isr_q, isr_d;
  logic [PIC_LEVEL_W-1:0] rot_q, rot_d;
  logic                   int_out_q, int_out_d;
  logic [NUM_IR-1:0]      irr_clear_q, irr_clear_d;
  logic [7:0]             data_out_q, data_out_d;
  logic                   data_oe_q, data_oe_d;
  logic [PIC_LEVEL_W-1:0] level_q, level_d;
  logic                   spurious_q, spurious_d;

  logic                   inta_fall, inta_rise;
  logic [NUM_IR-1:0]      isr_set;
  logic                   ack_done;
  logic [NUM_IR-1:0]      eoi_clr;
  logic [NUM_IR-1:0]      aeoi_clr;

  logic [2:0]             ocw2_cmd;
  logic [PIC_LEVEL_W-1:0] ocw2_lvl;

  logic [NUM_IR-1:0]      hi_onehot;
  logic [PIC_LEVEL_W-1:0] hi_level;
  logic                   hi_valid;

`ifdef PIC_AEOI_EN
  logic                   rot_in_aeoi_q, rot_in_aeoi_d;
`endif

  // inta_n is already synchronous; one register is enough for edge detection
  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

  assign ocw2_cmd = ocw2[7:5];
  assign ocw2_lvl = ocw2[2:0];

  pic_isr_highest u_isr_highest (
    .isr_i    (isr_q),
    .rotate_i (rot_q),
    .onehot_o (hi_onehot),
    .level_o  (hi_level),
    .valid_o  (hi_valid)
  );

  // --------------------------------------------------------------------------
  // Acknowledge FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    int_out_d   = 1'b0;
    irr_clear_d = '0;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;
    level_d     = level_q;
    spurious_d  = spurious_q;
    isr_set     = '0;
    ack_done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        int_out_d = |interrupt_vector;
        if (inta_fall) begin
          int_out_d = 1'b0;
          state_d   = ACK1;
          if (interrupt_vector == '0) begin
            // No winner by the time INTA arrived: answer with the spurious
            // level and leave ISR/IRR untouched.
            level_d    = SPURIOUS_LEVEL;
            spurious_d = 1'b1;
          end else begin
            level_d     = onehot_to_level(interrupt_vector);
            spurious_d  = 1'b0;
            isr_set     = interrupt_vector;
            irr_clear_d = interrupt_vector;
          end
        end
      end
      ACK1: begin
        if (inta_rise) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (inta_fall) begin
          state_d    = ACK2;
          data_out_d = {vector_base, level_q};
          data_oe_d  = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_d   = IDLE;
          data_oe_d = 1'b0;
          ack_done  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // OCW2 decode, ISR and rotation update
  // --------------------------------------------------------------------------
  always_comb begin
    eoi_clr  = '0;
    aeoi_clr = '0;
    rot_d    = rot_q;
`ifdef PIC_AEOI_EN
    rot_in_aeoi_d = rot_in_aeoi_q;

    if (ack_done && aeoi && !spurious_q) begin
      aeoi_clr = NUM_IR'(1) << level_q;
      if (rot_in_aeoi_q) begin
        rot_d = level_q + 3'd1;
      end
    end
`endif

    // An OCW2 rotate issued in the same cycle overrides an AEOI rotate.
    if (ocw2_wr) begin
      unique case (ocw2_cmd)
        NSEOI: begin
          eoi_clr = hi_onehot;
        end
        SEOI: begin
          eoi_clr = NUM_IR'(1) << ocw2_lvl;
        end
        ROT_NSEOI: begin
          // With nothing in service the rotate is skipped as well.
          if (hi_valid) begin
            eoi_clr = hi_onehot;
            rot_d   = hi_level + 3'd1;
          end
        end
        ROT_SEOI: begin
          eoi_clr = NUM_IR'(1) << ocw2_lvl;
          rot_d   = ocw2_lvl + 3'd1;
        end
        SET_PRI: begin
          rot_d = ocw2_lvl + 3'd1;
        end
        ROT_AEOI_SET: begin
`ifdef PIC_AEOI_EN
          rot_in_aeoi_d = 1'b1;
`endif
        end
        ROT_AEOI_CLR: begin
`ifdef PIC_AEOI_EN
          rot_in_aeoi_d = 1'b0;
`endif
        end
        default: begin
        end
      endcase
    end

    // Clears act on the old ISR; a same-cycle set is ORed afterwards and wins.
    isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | isr_set;
  end

`ifndef PIC_AEOI_EN
  logic unused_no_aeoi;
  assign unused_no_aeoi = ^{ack_done, spurious_q, ocw2[4:3]};
`else
  logic unused_ocw2_bits;
  assign unused_ocw2_bits = ^ocw2[4:3];
`endif

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      inta_q      <= 1'b1;
      isr_q       <= '0;
      rot_q       <= '0;
      int_out_q   <= 1'b0;
      irr_clear_q <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
      level_q     <= '0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_q      <= inta_n;
      isr_q       <= isr_d;
      rot_q       <= rot_d;
      int_out_q   <= int_out_d;
      irr_clear_q <= irr_clear_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      level_q     <= level_d;
      spurious_q  <= spurious_d;
    end
  end

`ifdef PIC_AEOI_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rot_in_aeoi_q <= 1'b0;
    end else begin
      rot_in_aeoi_q <= rot_in_aeoi_d;
    end
  end
`endif

  assign irr_clear       = irr_clear_q;
  assign isr             = isr_q;
  assign priority_rotate = rot_q;
  assign int_out         = int_out_q;
  assign data_out        = data_out_q;
  assign data_oe         = data_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_ack_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_ack_controller
// Purpose  : Scoreboard bench for pic_ack_controller. Stimulus tasks push the
//            expected IRR clears, vector bytes, data_oe lengths and state
//            snapshots into queues; a negedge monitor pops and compares them
//            whenever the DUT presents the corresponding output.
// Config   : PIC_AEOI_EN enables the auto-EOI scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_ack_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] interrupt_vector;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       ocw2_wr;
  logic [7:0] ocw2;
  logic [7:0] irr_clear;
  logic [7:0] isr;
  logic [2:0] priority_rotate;
  logic       int_out;
  logic [7:0] data_out;
  logic       data_oe;
`ifdef PIC_AEOI_EN
  logic       aeoi;
`endif

  pic_ack_controller dut (
    .clk              (clk),
    .reset            (reset),
    .interrupt_vector (interrupt_vector),
    .inta_n           (inta_n),
`ifdef PIC_AEOI_EN
    .aeoi             (aeoi),
`endif
    .vector_base      (vector_base),
    .ocw2_wr          (ocw2_wr),
    .ocw2             (ocw2),
    .irr_clear        (irr_clear),
    .isr              (isr),
    .priority_rotate  (priority_rotate),
    .int_out          (int_out),
    .data_out         (data_out),
    .data_oe          (data_oe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] isr;
    logic [2:0] rot;
    logic       int_o;
    logic       oe;
  } snap_t;

  snap_t      snap_q[$];
  logic [7:0] vec_q[$];
  logic [7:0] irr_q[$];
  int         oe_len_q[$];
  logic       chk_req = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    logic  prev_oe;
    int    oe_run;
    snap_t s;
    prev_oe = 1'b0;
    oe_run  = 0;
    forever begin
      @(negedge clk);
      if (chk_req) begin
        if (snap_q.size() == 0) begin
          cmp("snap_underflow", 1, 0);
        end else begin
          s = snap_q.pop_front();
          cmp("isr", {24'd0, isr}, {24'd0, s.isr});
          cmp("priority_rotate", {29'd0, priority_rotate}, {29'd0, s.rot});
          cmp("int_out", {31'd0, int_out}, {31'd0, s.int_o});
          cmp("data_oe", {31'd0, data_oe}, {31'd0, s.oe});
        end
      end
      if (irr_clear != 8'h00) begin
        if (irr_q.size() == 0) begin
          cmp("irr_clear_unexpected", {24'd0, irr_clear}, 0);
        end else begin
          cmp("irr_clear", {24'd0, irr_clear}, {24'd0, irr_q.pop_front()});
        end
      end
      if (data_oe && !prev_oe) begin
        if (vec_q.size() == 0) begin
          cmp("vector_unexpected", {24'd0, data_out}, 0);
        end else begin
          cmp("data_out", {24'd0, data_out}, {24'd0, vec_q.pop_front()});
        end
      end
      if (data_oe) begin
        oe_run++;
      end else if (prev_oe) begin
        if (oe_len_q.size() == 0) begin
          cmp("oe_len_unexpected", oe_run, 0);
        end else begin
          cmp("data_oe_length", oe_run, oe_len_q.pop_front());
        end
        oe_run = 0;
      end
      prev_oe = data_oe;
    end
  end

  // --------------------------------------------------------------- watchdog
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_snap(input logic [7:0] e_isr, input logic [2:0] e_rot,
                             input logic e_int, input logic e_oe);
    snap_q.push_back('{isr: e_isr, rot: e_rot, int_o: e_int, oe: e_oe});
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  task automatic write_ocw2(input logic [7:0] v);
    ocw2    = v;
    ocw2_wr = 1'b1;
    tick();
    ocw2_wr = 1'b0;
  endtask

  // Full two-pulse acknowledge. Optionally writes OCW2 in the cycle of the
  // first INTA fall, and changes the request after the first pulse.
  task automatic inta_cycle(input logic [7:0] exp_vec, input logic [7:0] exp_irr,
                            input logic with_ocw, input logic [7:0] ocw_v,
                            input logic [7:0] iv_after);
    if (exp_irr != 8'h00) irr_q.push_back(exp_irr);
    vec_q.push_back(exp_vec);
    oe_len_q.push_back(2);
    inta_n = 1'b0;
    if (with_ocw) begin
      ocw2    = ocw_v;
      ocw2_wr = 1'b1;
    end
    tick();
    ocw2_wr          = 1'b0;
    interrupt_vector = iv_after;
    tick();
    inta_n = 1'b1;
    tick();
    tick();
    inta_n = 1'b0;
    tick();
    tick();
    inta_n = 1'b1;
    tick();
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    reset            = 1'b1;
    interrupt_vector = 8'h00;
    inta_n           = 1'b1;
    vector_base      = 5'h11;
    ocw2_wr          = 1'b0;
    ocw2             = 8'h00;
`ifdef PIC_AEOI_EN
    aeoi             = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    expect_snap(8'h00, 3'd0, 1'b0, 1'b0);

    // T1: IR3 served, request changes after the first pulse
    interrupt_vector = 8'h08;
    tick();
    expect_snap(8'h00, 3'd0, 1'b1, 1'b0);
    inta_cycle(8'h8B, 8'h08, 1'b0, 8'h00, 8'h40);
    expect_snap(8'h08, 3'd0, 1'b0, 1'b0);
    interrupt_vector = 8'h00;
    tick();
    write_ocw2(8'h63);

    // T2: isr=0A, nonspecific then specific EOI
    interrupt_vector = 8'h02;
    inta_cycle(8'h89, 8'h02, 1'b0, 8'h00, 8'h00);
    interrupt_vector = 8'h08;
    inta_cycle(8'h8B, 8'h08, 1'b0, 8'h00, 8'h00);
    expect_snap(8'h0A, 3'd0, 1'b0, 1'b0);
    write_ocw2(8'h20);
    expect_snap(8'h08, 3'd0, 1'b0, 1'b0);
    write_ocw2(8'h63);
    expect_snap(8'h00, 3'd0, 1'b0, 1'b0);

    // T3: rotate on nonspecific EOI, then set priority with wrap 7 -> 0
    interrupt_vector = 8'h20;
    inta_cycle(8'h8D, 8'h20, 1'b0, 8'h00, 8'h00);
    expect_snap(8'h20, 3'd0, 1'b0, 1'b0);
    write_ocw2(8'hA0);
    expect_snap(8'h00, 3'd6, 1'b0, 1'b0);
    write_ocw2(8'hC7);
    expect_snap(8'h00, 3'd0, 1'b0, 1'b0);

    // Rotate-nonspecific EOI with empty ISR leaves rotation alone
    write_ocw2(8'hA0);
    expect_snap(8'h00, 3'd0, 1'b0, 1'b0);

    // Nonspecific EOI honours rotation: rot=5, isr bits 1 and 6 -> 6 first
    write_ocw2(8'hC4);
    interrupt_vector = 8'h02;
    inta_cycle(8'h89, 8'h02, 1'b0, 8'h00, 8'h00);
    interrupt_vector = 8'h40;
    inta_cycle(8'h8E, 8'h40, 1'b0, 8'h00, 8'h00);
    expect_snap(8'h42, 3'd5, 1'b0, 1'b0);
    write_ocw2(8'h20);
    expect_snap(8'h02, 3'd5, 1'b0, 1'b0);
    write_ocw2(8'hA0);
    expect_snap(8'h00, 3'd2, 1'b0, 1'b0);

    // T4: spurious acknowledge leaves isr unchanged
    interrupt_vector = 8'h01;
    inta_cycle(8'h88, 8'h01, 1'b0, 8'h00, 8'h00);
    expect_snap(8'h01, 3'd2, 1'b0, 1'b0);
    inta_cycle(8'h8F, 8'h00, 1'b0, 8'h00, 8'h00);
    expect_snap(8'h01, 3'd2, 1'b0, 1'b0);
    write_ocw2(8'h60);
    expect_snap(8'h00, 3'd2, 1'b0, 1'b0);

    // Same-cycle EOI and ISR set: clear old bit 4 while setting bit 3
    interrupt_vector = 8'h10;
    inta_cycle(8'h8C, 8'h10, 1'b0, 8'h00, 8'h00);
    interrupt_vector = 8'h08;
    inta_cycle(8'h8B, 8'h08, 1'b1, 8'h64, 8'h00);
    expect_snap(8'h08, 3'd2, 1'b0, 1'b0);
    // Same bit cleared and set in one cycle: the set wins
    interrupt_vector = 8'h08;
    inta_cycle(8'h8B, 8'h08, 1'b1, 8'h63, 8'h00);
    expect_snap(8'h08, 3'd2, 1'b0, 1'b0);
    write_ocw2(8'h63);
    expect_snap(8'h00, 3'd2, 1'b0, 1'b0);

    // T5: reset while in GAP abandons the cycle
    interrupt_vector = 8'h04;
    irr_q.push_back(8'h04);
    inta_n = 1'b0;
    tick();
    interrupt_vector = 8'h04;
    tick();
    inta_n = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_snap(8'h00, 3'd0, 1'b0, 1'b0);
    inta_cycle(8'h8A, 8'h04, 1'b0, 8'h00, 8'h00);
    expect_snap(8'h04, 3'd0, 1'b0, 1'b0);
    write_ocw2(8'h20);
    expect_snap(8'h00, 3'd0, 1'b0, 1'b0);

`ifdef PIC_AEOI_EN
    // T6: auto-EOI with rotation, serve IR2
    aeoi = 1'b1;
    write_ocw2(8'h80);
    interrupt_vector = 8'h04;
    inta_cycle(8'h8A, 8'h04, 1'b0, 8'h00, 8'h00);
    expect_snap(8'h00, 3'd3, 1'b0, 1'b0);
    aeoi = 1'b0;
`endif

    tick();
    tick();
    tick();
    cmp("leftover_vectors", vec_q.size(), 0);
    cmp("leftover_irr", irr_q.size(), 0);
    cmp("leftover_oe_len", oe_len_q.size(), 0);
    cmp("leftover_snaps", snap_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
